// File: rtl/scmp_debug_pkg.sv
// scmp_debug_pkg
// Shared definitions for the SC/MP front-panel debug controller:
//   - dbg_state_e : controller states (RUN, STEP_A, STEP_B, DEBUG)
//   - STAT_*      : bit positions of the CPU status flags on the data bus
//                   while ADS_n is low
//   - DEBUG_PAGE_DEFAULT : monitor page forced onto address bits [15:12]
package scmp_debug_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP_A = 2'd1,
        ST_STEP_B = 2'd2,
        ST_DEBUG  = 2'd3
    } dbg_state_e;

    localparam int STAT_H = 7;  // HALT instruction
    localparam int STAT_D = 6;  // delay
    localparam int STAT_I = 5;  // first byte of an instruction fetch
    localparam int STAT_R = 4;  // read cycle

    localparam logic [3:0] DEBUG_PAGE_DEFAULT = 4'h0;

endpackage

// File: rtl/scmp_ads_decode.sv
// scmp_ads_decode
// Detects the falling edge of the CPU address strobe and presents the
// HALT and instruction-fetch status flags captured with it.
// Ports:
//   clk      in  CPU clock
//   rst_n    in  asynchronous active-low reset
//   ads_n_i  in  CPU address strobe, active low
//   data_i   in  CPU data bus carrying status during ADS_n low
//   stb_o    out high for the single edge where ADS_n first goes low
//   h_o      out HALT status qualified by stb_o
//   i_o      out instruction-fetch status qualified by stb_o
module scmp_ads_decode
    import scmp_debug_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ads_n_i,
    input  logic [7:0] data_i,
    output logic       stb_o,
    output logic       h_o,
    output logic       i_o
);

    logic ads_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ads_prev_q <= 1'b1;
        end else begin
            ads_prev_q <= ads_n_i;
        end
    end

    // The strobe is combinational so the controller's state register acts on
    // the very edge that first sees ADS_n low; a held-low strobe fires once.
    assign stb_o = ads_prev_q & ~ads_n_i;
    assign h_o   = data_i[STAT_H];
    assign i_o   = data_i[STAT_I];

    // D and R status bits are not needed for mode control.
    logic unused_status;
    assign unused_status = ^{data_i[STAT_D], data_i[STAT_R], data_i[3:0]};

endmodule

// File: rtl/scmp_debug_ctrl.sv
// scmp_debug_ctrl
// Front-panel debug controller: switches between RUN, single-step and
// debug-monitor modes based on CPU status at address strobes, remaps the
// monitor page and gates the external bus address enable.
// Optional feature macro: SCMP_DEBUG_STEP_EN (single-step states).
// Ports:
//   clk, RST_n            clock and asynchronous active-low reset
//   ADS_n, BUSREQ_n       CPU bus strobes (active low)
//   DEBUG_n               external debug request (level, active low)
//   data[7:0]             CPU status during ADS_n low
//   halt_inst_toggle      0: HALT enters debug, 1: HALT is only a pulse
//   run_mode_toggle       0: single-step, 1: continuous on monitor exit
//   init_sw, halt_sw      panel switches (active high)
//   cpu_addr[15:0]        CPU address
//   mem_addr[15:0]        remapped address to memory
//   INDBG_n               low while in DEBUG
//   BAEN_n                external bus address enable, active low
module scmp_debug_ctrl
    import scmp_debug_pkg::*;
#(
    parameter logic [3:0] DEBUG_PAGE = DEBUG_PAGE_DEFAULT
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        ADS_n,
    input  logic        BUSREQ_n,
    input  logic        DEBUG_n,
    input  logic [7:0]  data,
    input  logic        halt_inst_toggle,
    input  logic        run_mode_toggle,
    input  logic        init_sw,
    input  logic        halt_sw,
    input  logic [15:0] cpu_addr,
    output logic [15:0] mem_addr,
    output logic        INDBG_n,
    output logic        BAEN_n
);

    logic       stb;
    logic       flag_h;
    logic       flag_i;
    dbg_state_e state_q, state_d;
    logic       pend_q, pend_d;
    logic       indbg_n_q;
    logic       pend_req;
    logic       pend_now;
    logic       enter_dbg;

    scmp_ads_decode u_ads_decode (
        .clk     (clk),
        .rst_n   (RST_n),
        .ads_n_i (ADS_n),
        .data_i  (data),
        .stb_o   (stb),
        .h_o     (flag_h),
        .i_o     (flag_i)
    );

    assign pend_req = halt_sw | ~DEBUG_n;
    // A request arriving on the strobe edge itself already counts.
    assign pend_now = pend_q | pend_req;

    always_comb begin
        state_d = state_q;
        if (stb) begin
            // H takes precedence over I whenever both are set.
            case (state_q)
                ST_RUN: begin
                    if (flag_h) begin
                        if (!halt_inst_toggle) state_d = ST_DEBUG;
                    end else if (flag_i && pend_now) begin
                        state_d = ST_DEBUG;
                    end
                end
`ifdef SCMP_DEBUG_STEP_EN
                ST_DEBUG: begin
                    if (flag_h) state_d = run_mode_toggle ? ST_RUN : ST_STEP_A;
                end
                ST_STEP_A: begin
                    if (flag_h) begin
                        if (!halt_inst_toggle) state_d = ST_DEBUG;
                    end else if (flag_i) begin
                        state_d = ST_STEP_B;
                    end
                end
                ST_STEP_B: begin
                    if (flag_h) begin
                        if (!halt_inst_toggle) state_d = ST_DEBUG;
                    end else if (flag_i) begin
                        state_d = ST_DEBUG;
                    end
                end
`else
                ST_DEBUG: begin
                    if (flag_h) state_d = ST_RUN;
                end
`endif
                default: state_d = ST_RUN;
            endcase
        end
        if (init_sw) state_d = ST_RUN;
    end

    assign enter_dbg = (state_d == ST_DEBUG) && (state_q != ST_DEBUG);

    always_comb begin
        pend_d = pend_q;
        if (init_sw || enter_dbg) begin
            pend_d = 1'b0;
        end else if (pend_req) begin
            pend_d = 1'b1;
        end
    end

`ifndef SCMP_DEBUG_STEP_EN
    // Without single-step the monitor always resumes continuous run.
    logic unused_run_mode;
    assign unused_run_mode = run_mode_toggle;
`endif

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_RUN;
            pend_q    <= 1'b0;
            indbg_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            indbg_n_q <= (state_d != ST_DEBUG);
        end
    end

    assign INDBG_n  = indbg_n_q;
    assign mem_addr = (state_q == ST_DEBUG) ? {DEBUG_PAGE, cpu_addr[11:0]} : cpu_addr;
    assign BAEN_n   = BUSREQ_n | (state_q == ST_DEBUG);

endmodule

// File: tb/tb_scmp_debug_ctrl.sv
module tb_scmp_debug_ctrl;

    logic        clk;
    logic        RST_n;
    logic        ADS_n;
    logic        BUSREQ_n;
    logic        DEBUG_n;
    logic [7:0]  data;
    logic        halt_inst_toggle;
    logic        run_mode_toggle;
    logic        init_sw;
    logic        halt_sw;
    logic [15:0] cpu_addr;
    logic [15:0] mem_addr;
    logic        INDBG_n;
    logic        BAEN_n;

    scmp_debug_ctrl dut (
        .clk              (clk),
        .RST_n            (RST_n),
        .ADS_n            (ADS_n),
        .BUSREQ_n         (BUSREQ_n),
        .DEBUG_n          (DEBUG_n),
        .data             (data),
        .halt_inst_toggle (halt_inst_toggle),
        .run_mode_toggle  (run_mode_toggle),
        .init_sw          (init_sw),
        .halt_sw          (halt_sw),
        .cpu_addr         (cpu_addr),
        .mem_addr         (mem_addr),
        .INDBG_n          (INDBG_n),
        .BAEN_n           (BAEN_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        indbg;
        logic        baen;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: pops every queued expectation when a sample is presented.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (mem_addr !== e.addr || INDBG_n !== e.indbg || BAEN_n !== e.baen) begin
                    n_errors++;
                    $display("FAIL %s: got mem_addr=%h INDBG_n=%b BAEN_n=%b, want mem_addr=%h INDBG_n=%b BAEN_n=%b",
                             e.name, mem_addr, INDBG_n, BAEN_n, e.addr, e.indbg, e.baen);
                end else begin
                    $display("ok   %s: mem_addr=%h INDBG_n=%b BAEN_n=%b", e.name, mem_addr, INDBG_n, BAEN_n);
                end
            end
        end
    end

    task automatic expect_now(input string nm, input logic [15:0] a, input logic ind, input logic ba);
        exp_t e;
        #1;
        e.name = nm; e.addr = a; e.indbg = ind; e.baen = ba;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // One address strobe lasting a single clock; returns on the following negedge.
    task automatic strobe(input logic [7:0] d);
        @(negedge clk);
        ADS_n = 1'b0;
        data  = d;
        @(posedge clk);
        #1;
        @(negedge clk);
        ADS_n = 1'b1;
        data  = 8'h00;
    endtask

    task automatic pulse_halt();
        @(negedge clk); halt_sw = 1'b1;
        @(negedge clk); halt_sw = 1'b0;
    endtask

    task automatic pulse_init();
        @(negedge clk); init_sw = 1'b1;
        @(negedge clk); init_sw = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        RST_n = 1'b0; ADS_n = 1'b1; BUSREQ_n = 1'b1; DEBUG_n = 1'b1;
        data = 8'h00; halt_inst_toggle = 1'b0; run_mode_toggle = 1'b1;
        init_sw = 1'b0; halt_sw = 1'b0; cpu_addr = 16'h7809;
        repeat (2) @(negedge clk);
        expect_now("reset_hold", 16'h7809, 1'b1, 1'b1);
        RST_n = 1'b1;
        @(negedge clk);
        expect_now("after_reset", 16'h7809, 1'b1, 1'b1);
        BUSREQ_n = 1'b0;
        expect_now("baen_follows_busreq", 16'h7809, 1'b1, 1'b0);

        // HALT enters debug when halt_inst_toggle=0
        strobe(8'h80);
        cpu_addr = 16'h7123;
        expect_now("halt_enters_debug", 16'h0123, 1'b0, 1'b1);

        // HALT in debug with continuous mode returns to RUN
        strobe(8'h80);
        expect_now("debug_halt_to_run", 16'h7123, 1'b1, 1'b0);

        // HALT as pulse only
        halt_inst_toggle = 1'b1;
        strobe(8'h80);
        expect_now("halt_pulse_only", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("ifetch_no_pend", 16'h7123, 1'b1, 1'b0);
        pulse_halt();
        strobe(8'h20);
        expect_now("pend_ifetch_debug", 16'h0123, 1'b0, 1'b1);

        // Exit with continuous mode; pend was consumed on entry
        strobe(8'h80);
        expect_now("debug_exit_run", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("run_stays_1", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("run_stays_2", 16'h7123, 1'b1, 1'b0);

        // Back to DEBUG, then try single-step
        halt_inst_toggle = 1'b0;
        strobe(8'h80);
        expect_now("reenter_debug", 16'h0123, 1'b0, 1'b1);
        run_mode_toggle = 1'b0;
`ifdef SCMP_DEBUG_STEP_EN
        strobe(8'h80);
        expect_now("step_a", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("step_b", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("step_back_debug", 16'h0123, 1'b0, 1'b1);
        strobe(8'h80);
        expect_now("step_a_again", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("step_b_again", 16'h7123, 1'b1, 1'b0);
        pulse_halt();
        pulse_init();
        expect_now("init_to_run", 16'h7123, 1'b1, 1'b0);
        strobe(8'h20);
        expect_now("init_cleared_pend", 16'h7123, 1'b1, 1'b0);
`else
        strobe(8'h80);
        expect_now("debug_exit_no_step", 16'h7123, 1'b1, 1'b0);
        pulse_halt();
        pulse_init();
        strobe(8'h20);
        expect_now("init_cleared_pend", 16'h7123, 1'b1, 1'b0);
`endif
        run_mode_toggle = 1'b1;

        // init_sw forces RUN from DEBUG
        strobe(8'h80);
        expect_now("debug_before_init", 16'h0123, 1'b0, 1'b1);
        pulse_init();
        expect_now("init_from_debug", 16'h7123, 1'b1, 1'b0);

        // A held-low ADS_n must produce only one strobe event
        @(negedge clk);
        ADS_n = 1'b0; data = 8'h80;
        repeat (3) @(negedge clk);
        expect_now("ads_hold_single_event", 16'h0123, 1'b0, 1'b1);
        ADS_n = 1'b1; data = 8'h00;
        strobe(8'h80);
        expect_now("exit_after_hold", 16'h7123, 1'b1, 1'b0);

        // DEBUG_n asserted in the same cycle as the fetch strobe
        @(negedge clk);
        ADS_n = 1'b0; data = 8'h20; DEBUG_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        ADS_n = 1'b1; data = 8'h00; DEBUG_n = 1'b1;
        expect_now("debugn_same_cycle", 16'h0123, 1'b0, 1'b1);

        // Pend set while in DEBUG, then asynchronous reset without a clock edge
        pulse_halt();
        @(negedge clk);
        #2;
        RST_n = 1'b0;
        expect_now("async_reset", 16'h7123, 1'b1, 1'b0);
        @(negedge clk);
        RST_n = 1'b1;
        strobe(8'h20);
        expect_now("reset_cleared_pend", 16'h7123, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scmp_debug_ctrl.md
# scmp_debug_ctrl

Front-panel debug controller for the SC/MP board top level. It watches the CPU's bus strobes and the status flags driven on the data bus during an address strobe. It switches the system between normal run, single-step and debug-monitor modes. In debug mode it remaps memory addresses into a monitor page and gates the external bus-address enable.

## Interface
Parameters:
- DEBUG_PAGE, default 4'h0: address bits [15:12] forced onto mem_addr while in debug mode.

Ports:
- clk  in  1  CPU clock; the only clock.
- RST_n  in  1  reset, asynchronous and active-low.
- ADS_n  in  1  CPU address strobe, active low.
- BUSREQ_n  in  1  bus cycle in progress, active low.
- DEBUG_n  in  1  external debug request, active low, level-sensitive.
- data  in  8  CPU data-out bus. Status bits are valid while ADS_n=0: [7]=H (halt), [6]=D, [5]=I (first instruction byte fetch), [4]=R.
- halt_inst_toggle  in  1  0 = HALT enters debug; 1 = HALT is a pulse only.
- run_mode_toggle  in  1  0 = single-step; 1 = continuous.
- init_sw  in  1  panel INIT, active high.
- halt_sw  in  1  panel HALT request, active high (may be a 1-cycle pulse).
- cpu_addr  in  16  full CPU address (latched high nibble & 12-bit address).
- mem_addr  out  16  address presented to memory/decoding.
- INDBG_n  out  1  low while in DEBUG state.
- BAEN_n  out  1  external bus address enable, active low.

## Operation
- **Strobe event:** the first clk edge at which ADS_n=0 while the registered previous ADS_n=1. On that edge, H and I are sampled from data[7] and data[5]. A continuous low ADS_n yields one event.
- **Pending request flag (pend):**
  - Set on any edge where halt_sw=1 or DEBUG_n=0.
  - Cleared on entry to DEBUG or when init_sw=1.
- **States:** RUN, STEP_A, STEP_B, DEBUG. Transitions are evaluated at strobe events only, except init_sw.
  - RUN → DEBUG when H=1 and halt_inst_toggle=0.
  - RUN → DEBUG when I=1 and pend=1.
  - RUN: HALT with halt_inst_toggle=1 causes no change.
  - DEBUG → STEP_A when H=1 and run_mode_toggle=0; DEBUG → RUN when H=1 and run_mode_toggle=1. The monitor leaves debug by executing HALT.
  - STEP_A → STEP_B on I=1 (the one user instruction).
  - STEP_B → DEBUG on the next I=1.
  - STEP_A/STEP_B → DEBUG on H=1 with halt_inst_toggle=0.
- **init_sw=1:** synchronously forces RUN and clears pend. It has highest priority.
- **Simultaneous conditions:** H and I in the same strobe → the H rule applies. A pend request arriving in the same cycle as a qualifying strobe counts as pending.
- **mem_addr:**
  - DEBUG: {DEBUG_PAGE, cpu_addr[11:0]}.
  - Otherwise: cpu_addr.
  - Combinational from the registered state.
- **INDBG_n** = 0 exactly when state = DEBUG (registered state decode).
- **BAEN_n** = BUSREQ_n | (state==DEBUG). Combinational.

## Timing
- Reset values: state RUN, pend 0, previous ADS_n 1, INDBG_n 1.
- After reset, mem_addr equals cpu_addr and BAEN_n equals BUSREQ_n.
- A state change takes effect one clk after the strobe edge. The bus cycle opened by the entry strobe therefore reads with the new mapping (RD_n follows ADS_n by ≥1 cycle).
- RST_n low mid-operation: immediate return to reset values, with no clock needed.
- mem_addr and BAEN_n have zero latency from cpu_addr and BUSREQ_n.

## Configuration
- **SCMP_DEBUG_STEP_EN defined:** single-step supported as above.
- **Not defined:**
  - STEP_A/STEP_B are absent.
  - run_mode_toggle is ignored.
  - A HALT in DEBUG always returns to RUN.

## Structure
- Package scmp_debug_pkg holds:
  - the state enum (RUN, STEP_A, STEP_B, DEBUG);
  - status bit index constants (H=7, D=6, I=5, R=4);
  - the default DEBUG_PAGE.
- One natural sub-module, scmp_ads_decode: ADS_n edge detect and H/I capture, producing a 1-cycle strobe with flags.

## Test plan
- Reset, then cpu_addr=16'h7809 → mem_addr=16'h7809, INDBG_n=1, BAEN_n follows BUSREQ_n.
- halt_inst_toggle=0, strobe with data=8'h80 → INDBG_n=0 next cycle; cpu_addr=16'h7123 gives mem_addr=16'h0123; BAEN_n=1 with BUSREQ_n=0.
- halt_inst_toggle=1, HALT strobe in RUN → INDBG_n stays 1. Then a 1-cycle halt_sw pulse and a strobe with data=8'h20 → DEBUG.
- In DEBUG with run_mode_toggle=0, strobe data=8'h80 → STEP_A (INDBG_n=1); strobe 8'h20 → STEP_B; next strobe 8'h20 → DEBUG.
- In DEBUG with run_mode_toggle=1, HALT strobe → RUN; further 8'h20 strobes keep RUN.
- In STEP_B, init_sw=1 → RUN and pend cleared. RST_n low with no clock edge → INDBG_n=1 immediately.
